// File: rtl/mem_issue_queue_if.sv
// mem_issue_queue_if
//   Bundles every signal between the memory issue queue and its neighbours:
//   dispatch/rename (request side), the two result broadcast buses, and
//   mem_ctrl (issue side).
//
//   Handshake semantics:
//     - Dispatch: an entry is transferred on a rising edge where
//       disp_valid && disp_ready && !flush. disp_ready depends only on the
//       queue state, never on disp_valid or on a same-cycle issue.
//     - Issue: mem_issue_en is a single-cycle strobe. It is only raised while
//       mem_ready is high, so every strobe is a completed transfer. The
//       mem_issue_queue_* fields are held stable while mem_ready is low.
//
//   Modports:
//     master - the environment (dispatch, cdb sources, mem_ctrl, flush)
//     slave  - the issue queue itself
interface mem_issue_queue_if #(
  parameter int DEPTH        = 8,
  parameter int WORD_WIDTH   = 32,
  parameter int MEM_OP_WIDTH = 4,
  parameter int TAG_WIDTH    = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                    flush;

  logic                    disp_valid;
  logic                    disp_ready;
  logic [MEM_OP_WIDTH-1:0] disp_op;
  logic [WORD_WIDTH-1:0]   disp_imm;
  logic                    disp_rs1_ready;
  logic [TAG_WIDTH-1:0]    disp_rs1_tag;
  logic [WORD_WIDTH-1:0]   disp_rs1_value;
  logic                    disp_rs2_ready;
  logic [TAG_WIDTH-1:0]    disp_rs2_tag;
  logic [WORD_WIDTH-1:0]   disp_rs2_value;
  logic [TAG_WIDTH-1:0]    disp_Pdst;

  logic                    cdb0_valid;
  logic [TAG_WIDTH-1:0]    cdb0_tag;
  logic [WORD_WIDTH-1:0]   cdb0_value;
  logic                    cdb1_valid;
  logic [TAG_WIDTH-1:0]    cdb1_tag;
  logic [WORD_WIDTH-1:0]   cdb1_value;

  logic                    mem_ready;
  logic                    mem_issue_en;
  logic [MEM_OP_WIDTH-1:0] mem_issue_queue_op;
  logic [WORD_WIDTH-1:0]   mem_issue_queue_imm;
  logic [WORD_WIDTH-1:0]   mem_issue_queue_rs1_value;
  logic [WORD_WIDTH-1:0]   mem_issue_queue_rs2_value;
  logic [TAG_WIDTH-1:0]    mem_issue_queue_Pdst;

  logic [CNT_W-1:0]        count;

  modport master (
    output flush,
    output disp_valid, disp_op, disp_imm,
    output disp_rs1_ready, disp_rs1_tag, disp_rs1_value,
    output disp_rs2_ready, disp_rs2_tag, disp_rs2_value, disp_Pdst,
    output cdb0_valid, cdb0_tag, cdb0_value,
    output cdb1_valid, cdb1_tag, cdb1_value,
    output mem_ready,
    input  disp_ready,
    input  mem_issue_en, mem_issue_queue_op, mem_issue_queue_imm,
    input  mem_issue_queue_rs1_value, mem_issue_queue_rs2_value,
    input  mem_issue_queue_Pdst,
    input  count
  );

  modport slave (
    input  flush,
    input  disp_valid, disp_op, disp_imm,
    input  disp_rs1_ready, disp_rs1_tag, disp_rs1_value,
    input  disp_rs2_ready, disp_rs2_tag, disp_rs2_value, disp_Pdst,
    input  cdb0_valid, cdb0_tag, cdb0_value,
    input  cdb1_valid, cdb1_tag, cdb1_value,
    input  mem_ready,
    output disp_ready,
    output mem_issue_en, mem_issue_queue_op, mem_issue_queue_imm,
    output mem_issue_queue_rs1_value, mem_issue_queue_rs2_value,
    output mem_issue_queue_Pdst,
    output count
  );
endinterface

// File: rtl/mem_issue_queue.sv
// mem_issue_queue
//   In-order issue queue for the load/store unit. Buffers memory micro-ops
//   with their base (rs1) and store-data (rs2) operands, captures missing
//   operands from two result broadcast buses, and issues the oldest entry to
//   mem_ctrl once both operands are ready and mem_ready is high. Strict
//   program-order issue keeps memory ordering without disambiguation.
//
//   Ports:
//     clk - single clock, rising edge
//     rst - asynchronous, active-high reset
//     q   - mem_issue_queue_if.slave: flush, dispatch request/ready,
//           cdb0/cdb1 broadcasts, mem_ready, issue strobe + fields, count
module mem_issue_queue #(
  parameter int DEPTH        = 8,
  parameter int WORD_WIDTH   = 32,
  parameter int MEM_OP_WIDTH = 4,
  parameter int TAG_WIDTH    = 5
) (
  input  logic              clk,
  input  logic              rst,
  mem_issue_queue_if.slave  q
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Memory op encoding.
  localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_LB  = MEM_OP_WIDTH'(4'h0);
  localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_LH  = MEM_OP_WIDTH'(4'h1);
  localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_LW  = MEM_OP_WIDTH'(4'h2);
  localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_LBU = MEM_OP_WIDTH'(4'h4);
  localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_LHU = MEM_OP_WIDTH'(4'h5);

  // Entry storage
  logic [DEPTH-1:0]        valid_q;
  logic [DEPTH-1:0]        rs1_rdy_q;
  logic [DEPTH-1:0]        rs2_rdy_q;
  logic [MEM_OP_WIDTH-1:0] op_q      [DEPTH];
  logic [WORD_WIDTH-1:0]   imm_q     [DEPTH];
  logic [TAG_WIDTH-1:0]    pdst_q    [DEPTH];
  logic [TAG_WIDTH-1:0]    rs1_tag_q [DEPTH];
  logic [WORD_WIDTH-1:0]   rs1_val_q [DEPTH];
  logic [TAG_WIDTH-1:0]    rs2_tag_q [DEPTH];
  logic [WORD_WIDTH-1:0]   rs2_val_q [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             empty, full, push, pop, head_rdy;

  assign wr_idx   = wr_ptr_q[IDX_W-1:0];
  assign rd_idx   = rd_ptr_q[IDX_W-1:0];
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign head_rdy = rs1_rdy_q[rd_idx] && rs2_rdy_q[rd_idx];

  // disp_ready looks only at the registered state, so a full queue refuses
  // dispatch even in a cycle where the head issues.
  assign push = q.disp_valid && !full && !q.flush;
  assign pop  = !empty && head_rdy && q.mem_ready && !q.flush;

  assign q.disp_ready   = !full;
  assign q.mem_issue_en = pop;
  assign q.count        = wr_ptr_q - rd_ptr_q;

  // Dispatch-time operand resolution, including same-cycle cdb snoop.
  // cdb0 wins over cdb1 when both carry the wanted tag.
  logic                  disp_is_load;
  logic                  disp_rs1_rdy, disp_rs2_rdy;
  logic [WORD_WIDTH-1:0] disp_rs1_val, disp_rs2_val;

  always_comb begin
    disp_is_load = (q.disp_op == MEM_OP_LB)  || (q.disp_op == MEM_OP_LH)  ||
                   (q.disp_op == MEM_OP_LW)  || (q.disp_op == MEM_OP_LBU) ||
                   (q.disp_op == MEM_OP_LHU);
    disp_rs1_rdy = q.disp_rs1_ready;
    disp_rs1_val = q.disp_rs1_value;
    disp_rs2_rdy = q.disp_rs2_ready;
    disp_rs2_val = q.disp_rs2_value;

    if (!q.disp_rs1_ready) begin
      if (q.cdb0_valid && (q.cdb0_tag == q.disp_rs1_tag)) begin
        disp_rs1_rdy = 1'b1;
        disp_rs1_val = q.cdb0_value;
      end else if (q.cdb1_valid && (q.cdb1_tag == q.disp_rs1_tag)) begin
        disp_rs1_rdy = 1'b1;
        disp_rs1_val = q.cdb1_value;
      end
    end

    // Loads have no store data; their rs2 is treated as always ready.
    if (disp_is_load) begin
      disp_rs2_rdy = 1'b1;
    end else if (!q.disp_rs2_ready) begin
      if (q.cdb0_valid && (q.cdb0_tag == q.disp_rs2_tag)) begin
        disp_rs2_rdy = 1'b1;
        disp_rs2_val = q.cdb0_value;
      end else if (q.cdb1_valid && (q.cdb1_tag == q.disp_rs2_tag)) begin
        disp_rs2_rdy = 1'b1;
        disp_rs2_val = q.cdb1_value;
      end
    end
  end

  // Wakeup of stored entries; same cdb0-over-cdb1 priority as dispatch.
  logic [DEPTH-1:0]      wake1, wake2;
  logic [WORD_WIDTH-1:0] wake1_val [DEPTH];
  logic [WORD_WIDTH-1:0] wake2_val [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wake1[i]     = 1'b0;
      wake2[i]     = 1'b0;
      wake1_val[i] = '0;
      wake2_val[i] = '0;
      if (valid_q[i] && !rs1_rdy_q[i]) begin
        if (q.cdb0_valid && (q.cdb0_tag == rs1_tag_q[i])) begin
          wake1[i]     = 1'b1;
          wake1_val[i] = q.cdb0_value;
        end else if (q.cdb1_valid && (q.cdb1_tag == rs1_tag_q[i])) begin
          wake1[i]     = 1'b1;
          wake1_val[i] = q.cdb1_value;
        end
      end
      if (valid_q[i] && !rs2_rdy_q[i]) begin
        if (q.cdb0_valid && (q.cdb0_tag == rs2_tag_q[i])) begin
          wake2[i]     = 1'b1;
          wake2_val[i] = q.cdb0_value;
        end else if (q.cdb1_valid && (q.cdb1_tag == rs2_tag_q[i])) begin
          wake2[i]     = 1'b1;
          wake2_val[i] = q.cdb1_value;
        end
      end
    end
  end

  // A push never targets a valid slot (queue not full), so wakeup and the
  // push write never collide on the same entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      valid_q   <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]      <= '0;
        imm_q[i]     <= '0;
        pdst_q[i]    <= '0;
        rs1_tag_q[i] <= '0;
        rs1_val_q[i] <= '0;
        rs2_tag_q[i] <= '0;
        rs2_val_q[i] <= '0;
      end
    end else if (q.flush) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      valid_q   <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wake1[i]) begin
          rs1_rdy_q[i] <= 1'b1;
          rs1_val_q[i] <= wake1_val[i];
        end
        if (wake2[i]) begin
          rs2_rdy_q[i] <= 1'b1;
          rs2_val_q[i] <= wake2_val[i];
        end
      end
      if (pop) begin
        valid_q[rd_idx] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        valid_q[wr_idx]   <= 1'b1;
        op_q[wr_idx]      <= q.disp_op;
        imm_q[wr_idx]     <= q.disp_imm;
        pdst_q[wr_idx]    <= q.disp_Pdst;
        rs1_tag_q[wr_idx] <= q.disp_rs1_tag;
        rs1_rdy_q[wr_idx] <= disp_rs1_rdy;
        rs1_val_q[wr_idx] <= disp_rs1_val;
        rs2_tag_q[wr_idx] <= q.disp_rs2_tag;
        rs2_rdy_q[wr_idx] <= disp_rs2_rdy;
        rs2_val_q[wr_idx] <= disp_rs2_val;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
    end
  end

  // Head presentation; zeros whenever the queue is empty.
  always_comb begin
    q.mem_issue_queue_op        = '0;
    q.mem_issue_queue_imm       = '0;
    q.mem_issue_queue_rs1_value = '0;
    q.mem_issue_queue_rs2_value = '0;
    q.mem_issue_queue_Pdst      = '0;
    if (!empty) begin
      q.mem_issue_queue_op        = op_q[rd_idx];
      q.mem_issue_queue_imm       = imm_q[rd_idx];
      q.mem_issue_queue_rs1_value = rs1_val_q[rd_idx];
      q.mem_issue_queue_rs2_value = rs2_val_q[rd_idx];
      q.mem_issue_queue_Pdst      = pdst_q[rd_idx];
    end
  end
endmodule

// File: tb/tb_mem_issue_queue.sv
// tb_mem_issue_queue
//   Directed testbench for mem_issue_queue. Inputs change 1 ns after the
//   rising edge; outputs are sampled 1 ns later, well away from the edge.
module tb_mem_issue_queue;
  localparam int DEPTH        = 8;
  localparam int WORD_WIDTH   = 32;
  localparam int MEM_OP_WIDTH = 4;
  localparam int TAG_WIDTH    = 5;

  localparam logic [3:0] OP_LW = 4'h2;
  localparam logic [3:0] OP_SW = 4'hA;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_issue_queue_if #(
    .DEPTH(DEPTH), .WORD_WIDTH(WORD_WIDTH),
    .MEM_OP_WIDTH(MEM_OP_WIDTH), .TAG_WIDTH(TAG_WIDTH)
  ) qi ();

  mem_issue_queue #(
    .DEPTH(DEPTH), .WORD_WIDTH(WORD_WIDTH),
    .MEM_OP_WIDTH(MEM_OP_WIDTH), .TAG_WIDTH(TAG_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .q   (qi)
  );

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [TAG_WIDTH-1:0]  exp_q[$];
  logic [WORD_WIDTH-1:0] exp_rs1_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    qi.flush          = 1'b0;
    qi.disp_valid     = 1'b0;
    qi.disp_op        = '0;
    qi.disp_imm       = '0;
    qi.disp_rs1_ready = 1'b0;
    qi.disp_rs1_tag   = '0;
    qi.disp_rs1_value = '0;
    qi.disp_rs2_ready = 1'b0;
    qi.disp_rs2_tag   = '0;
    qi.disp_rs2_value = '0;
    qi.disp_Pdst      = '0;
    qi.cdb0_valid     = 1'b0;
    qi.cdb0_tag       = '0;
    qi.cdb0_value     = '0;
    qi.cdb1_valid     = 1'b0;
    qi.cdb1_tag       = '0;
    qi.cdb1_value     = '0;
  endtask

  task automatic dispatch(input logic [3:0] op, input logic [31:0] imm,
                          input logic r1_rdy, input logic [4:0] r1_tag, input logic [31:0] r1_val,
                          input logic r2_rdy, input logic [4:0] r2_tag, input logic [31:0] r2_val,
                          input logic [4:0] pdst);
    qi.disp_valid     = 1'b1;
    qi.disp_op        = op;
    qi.disp_imm       = imm;
    qi.disp_rs1_ready = r1_rdy;
    qi.disp_rs1_tag   = r1_tag;
    qi.disp_rs1_value = r1_val;
    qi.disp_rs2_ready = r2_rdy;
    qi.disp_rs2_tag   = r2_tag;
    qi.disp_rs2_value = r2_val;
    qi.disp_Pdst      = pdst;
  endtask

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    clear_inputs();
    qi.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_disp_ready", 64'(qi.disp_ready), 64'd1);
    check("rst_issue_en",   64'(qi.mem_issue_en), 64'd0);
    check("rst_count",      64'(qi.count), 64'd0);
    check("rst_rs1",        64'(qi.mem_issue_queue_rs1_value), 64'd0);
    rst = 1'b0;
    tick();

    // ---------------- 1-cycle latency LW ----------------
    dispatch(OP_LW, 32'd4, 1'b1, 5'd0, 32'h100, 1'b0, 5'd0, 32'h0, 5'd3);
    #1;
    check("lat_c0_issue_en", 64'(qi.mem_issue_en), 64'd0);
    tick();
    clear_inputs();
    #1;
    check("lat_c1_issue_en", 64'(qi.mem_issue_en), 64'd1);
    check("lat_c1_rs1",      64'(qi.mem_issue_queue_rs1_value), 64'h100);
    check("lat_c1_imm",      64'(qi.mem_issue_queue_imm), 64'd4);
    check("lat_c1_pdst",     64'(qi.mem_issue_queue_Pdst), 64'd3);
    check("lat_c1_op",       64'(qi.mem_issue_queue_op), 64'(OP_LW));
    check("lat_c1_count",    64'(qi.count), 64'd1);
    tick();
    #1;
    check("lat_c2_count",    64'(qi.count), 64'd0);
    check("lat_c2_issue_en", 64'(qi.mem_issue_en), 64'd0);

    // ---------------- SW waits on cdb1, LW behind it ----------------
    tick();
    dispatch(OP_SW, 32'd8, 1'b1, 5'd0, 32'h200, 1'b0, 5'd7, 32'h0, 5'd4);
    tick();
    dispatch(OP_LW, 32'd0, 1'b1, 5'd0, 32'h300, 1'b0, 5'd0, 32'h0, 5'd5);
    #1;
    check("sw_wait_issue_en", 64'(qi.mem_issue_en), 64'd0);
    check("sw_wait_head",     64'(qi.mem_issue_queue_Pdst), 64'd4);
    tick();
    clear_inputs();
    qi.cdb1_valid = 1'b1;
    qi.cdb1_tag   = 5'd7;
    qi.cdb1_value = 32'hDEAD;
    #1;
    check("sw_no_bypass",  64'(qi.mem_issue_en), 64'd0);
    check("sw_count2",     64'(qi.count), 64'd2);
    tick();
    clear_inputs();
    #1;
    check("sw_issue_en",   64'(qi.mem_issue_en), 64'd1);
    check("sw_pdst",       64'(qi.mem_issue_queue_Pdst), 64'd4);
    check("sw_rs2",        64'(qi.mem_issue_queue_rs2_value), 64'hDEAD);
    check("sw_rs1",        64'(qi.mem_issue_queue_rs1_value), 64'h200);
    check("sw_imm",        64'(qi.mem_issue_queue_imm), 64'd8);
    tick();
    #1;
    check("lw2_issue_en",  64'(qi.mem_issue_en), 64'd1);
    check("lw2_pdst",      64'(qi.mem_issue_queue_Pdst), 64'd5);
    check("lw2_rs1",       64'(qi.mem_issue_queue_rs1_value), 64'h300);
    tick();
    #1;
    check("sw_done_count", 64'(qi.count), 64'd0);

    // ---------------- fill, overflow refusal, drain with wrap ----------------
    qi.mem_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      dispatch(OP_LW, 32'(i), 1'b1, 5'd0, 32'h1000 + 32'(i), 1'b0, 5'd0, 32'h0, 5'(8 + i));
      exp_q.push_back(5'(8 + i));
      exp_rs1_q.push_back(32'h1000 + 32'(i));
      tick();
    end
    clear_inputs();
    #1;
    check("full_count",      64'(qi.count), 64'd8);
    check("full_disp_ready", 64'(qi.disp_ready), 64'd0);
    check("full_hold_en",    64'(qi.mem_issue_en), 64'd0);
    check("full_hold_head",  64'(qi.mem_issue_queue_Pdst), 64'd8);
    dispatch(OP_LW, 32'd0, 1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'h0, 5'd31);
    tick();
    clear_inputs();
    #1;
    check("ovf_count",       64'(qi.count), 64'd8);
    check("ovf_head",        64'(qi.mem_issue_queue_Pdst), 64'd8);
    // Dispatch offered in the same cycle as the first pop must be refused.
    qi.mem_ready = 1'b1;
    dispatch(OP_LW, 32'd0, 1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'h0, 5'd30);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      if (i == 0) check("pop_full_disp_ready", 64'(qi.disp_ready), 64'd0);
      check($sformatf("drain%0d_en", i), 64'(qi.mem_issue_en), 64'd1);
      check($sformatf("drain%0d_pdst", i), 64'(qi.mem_issue_queue_Pdst), 64'(exp_q.pop_front()));
      check($sformatf("drain%0d_rs1", i), 64'(qi.mem_issue_queue_rs1_value), 64'(exp_rs1_q.pop_front()));
      tick();
      clear_inputs();
    end
    #1;
    check("drain_count",    64'(qi.count), 64'd0);
    check("drain_issue_en", 64'(qi.mem_issue_en), 64'd0);

    // ---------------- dispatch-time snoop ----------------
    tick();
    dispatch(OP_LW, 32'd0, 1'b0, 5'd5, 32'h0, 1'b0, 5'd0, 32'h0, 5'd6);
    qi.cdb0_valid = 1'b1;
    qi.cdb0_tag   = 5'd5;
    qi.cdb0_value = 32'h40;
    qi.cdb1_valid = 1'b1;
    qi.cdb1_tag   = 5'd5;
    qi.cdb1_value = 32'h99;
    #1;
    check("snoop_c0_en", 64'(qi.mem_issue_en), 64'd0);
    tick();
    clear_inputs();
    #1;
    check("snoop_en",  64'(qi.mem_issue_en), 64'd1);
    check("snoop_rs1", 64'(qi.mem_issue_queue_rs1_value), 64'h40);
    tick();
    dispatch(OP_SW, 32'd0, 1'b1, 5'd0, 32'h10, 1'b0, 5'd9, 32'h0, 5'd7);
    qi.cdb1_valid = 1'b1;
    qi.cdb1_tag   = 5'd9;
    qi.cdb1_value = 32'h77;
    tick();
    clear_inputs();
    #1;
    check("snoop_sw_en",  64'(qi.mem_issue_en), 64'd1);
    check("snoop_sw_rs2", 64'(qi.mem_issue_queue_rs2_value), 64'h77);
    tick();
    #1;
    check("snoop_count", 64'(qi.count), 64'd0);

    // ---------------- flush with concurrent dispatch ----------------
    tick();
    qi.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dispatch(OP_LW, 32'd0, 1'b1, 5'd0, 32'h500 + 32'(i), 1'b0, 5'd0, 32'h0, 5'(20 + i));
      tick();
    end
    clear_inputs();
    qi.flush     = 1'b1;
    qi.mem_ready = 1'b1;
    dispatch(OP_LW, 32'd0, 1'b1, 5'd0, 32'h600, 1'b0, 5'd0, 32'h0, 5'd24);
    #1;
    check("flush_c0_count", 64'(qi.count), 64'd4);
    check("flush_c0_en",    64'(qi.mem_issue_en), 64'd0);
    tick();
    clear_inputs();
    #1;
    check("flush_count",      64'(qi.count), 64'd0);
    check("flush_en",         64'(qi.mem_issue_en), 64'd0);
    check("flush_pdst",       64'(qi.mem_issue_queue_Pdst), 64'd0);
    check("flush_disp_ready", 64'(qi.disp_ready), 64'd1);
    dispatch(OP_LW, 32'd0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0, 5'd25);
    tick();
    clear_inputs();
    #1;
    check("post_flush_pdst", 64'(qi.mem_issue_queue_Pdst), 64'd25);
    check("post_flush_en",   64'(qi.mem_issue_en), 64'd1);
    tick();

    // ---------------- asynchronous reset mid-stream ----------------
    qi.mem_ready = 1'b0;
    dispatch(OP_LW, 32'd0, 1'b1, 5'd0, 32'h700, 1'b0, 5'd0, 32'h0, 5'd12);
    tick();
    dispatch(OP_LW, 32'd0, 1'b1, 5'd0, 32'h701, 1'b0, 5'd0, 32'h0, 5'd13);
    tick();
    clear_inputs();
    qi.mem_ready = 1'b1;
    #1;
    check("pre_rst_en",   64'(qi.mem_issue_en), 64'd1);
    check("pre_rst_pdst", 64'(qi.mem_issue_queue_Pdst), 64'd12);
    #1;
    rst = 1'b1;
    #1;
    check("arst_en",         64'(qi.mem_issue_en), 64'd0);
    check("arst_count",      64'(qi.count), 64'd0);
    check("arst_disp_ready", 64'(qi.disp_ready), 64'd1);
    check("arst_pdst",       64'(qi.mem_issue_queue_Pdst), 64'd0);
    check("arst_rs1",        64'(qi.mem_issue_queue_rs1_value), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_issue_queue.md
# mem_issue_queue

In-order issue queue for the load/store unit, sitting between dispatch/rename and `mem_ctrl`. It buffers memory micro-ops with their rs1 (base) and rs2 (store-data) operands, and captures missing operands from two result broadcast buses. It presents the oldest entry to `mem_ctrl` once its operands are ready and `mem_ready` is high. Issue is strictly in program order, so memory ordering is preserved without a disambiguation unit.

## Interface
- `DEPTH`, 8: number of entries; must be a power of two and at least 2.
- `WORD_WIDTH`, 32: operand width.
- `MEM_OP_WIDTH`, 4: width of the memory op encoding.
- `TAG_WIDTH`, 5: `$clog2(ROB_DEPTH)`; ROB tag width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: pipeline flush (mispredict/exception); empties the queue.
- `disp_valid` in 1: dispatch request.
- `disp_ready` out 1: queue can accept; equals `count < DEPTH`.
- `disp_op` in MEM_OP_WIDTH: `MEM_OP_*` encoding.
- `disp_imm` in WORD_WIDTH: sign-extended offset.
- `disp_rs1_ready` in 1: rs1 value is valid at dispatch.
- `disp_rs1_tag` in TAG_WIDTH: producer tag of rs1.
- `disp_rs1_value` in WORD_WIDTH: rs1 value.
- `disp_rs2_ready` in 1: rs2 value is valid at dispatch.
- `disp_rs2_tag` in TAG_WIDTH: producer tag of rs2.
- `disp_rs2_value` in WORD_WIDTH: rs2 value.
- `disp_Pdst` in TAG_WIDTH: destination ROB tag.
- `cdb0_valid`, `cdb1_valid` in 1: result broadcast valid (ALU, load writeback).
- `cdb0_tag`, `cdb1_tag` in TAG_WIDTH: broadcast tag.
- `cdb0_value`, `cdb1_value` in WORD_WIDTH: broadcast value.
- `mem_ready` in 1: `mem_ctrl` can accept an issue this cycle.
- `mem_issue_en` out 1: issue strobe.
- `mem_issue_queue_op` out MEM_OP_WIDTH: op of the issued entry.
- `mem_issue_queue_imm` out WORD_WIDTH: imm of the issued entry.
- `mem_issue_queue_rs1_value` out WORD_WIDTH: base value.
- `mem_issue_queue_rs2_value` out WORD_WIDTH: store-data value.
- `mem_issue_queue_Pdst` out TAG_WIDTH: destination tag of the issued entry.
- `count` out `$clog2(DEPTH)+1`: occupancy.

## Operation
- Storage is a circular buffer with `wr_ptr`/`rd_ptr` of `$clog2(DEPTH)+1` bits; the MSB is the wrap bit.
  - Empty when the pointers are equal.
  - Full when the index bits are equal and the wrap bits differ.
  - Pointers wrap naturally from `DEPTH-1` to 0.
- Per-entry fields: valid, op, imm, Pdst, rs1_{rdy,tag,val}, rs2_{rdy,tag,val}.
- Push occurs when `disp_valid && disp_ready && !flush`. The entry is written at `wr_ptr`, which then increments.
  - Load ops (`LW/LH/LHU/LB/LBU`) force `rs2_rdy=1`; the rs2 value is don't-care.
  - Dispatch snoop: if a not-ready source tag matches a valid cdb in the same cycle, the cdb value is captured and `rdy=1` is written.
  - cdb0 has priority over cdb1 on a duplicate tag match.
- Wakeup: every valid entry compares each not-ready source tag against both cdbs every cycle. On a match, the value and `rdy=1` are latched at the next edge.
- Issue is combinational from the head entry.
  - `mem_issue_en = !empty && head.rs1_rdy && head.rs2_rdy && mem_ready && !flush`.
  - When `!empty`, the data outputs carry the head fields; when empty, they are 0.
- Pop: on `mem_issue_en`, the head is invalidated and `rd_ptr` increments at the edge.
- Younger ready entries never bypass an unready head.
- `count` update:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged.
- Flush: at the next edge, all entries are invalidated and both pointers and `count` return to 0. Flush dominates a same-cycle push and pop.

## Timing
- Reset (async, active-high) clears:
  - all valid bits, pointers and `count` to 0;
  - `mem_issue_en` to 0, all data outputs to 0, `disp_ready` to 1.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Minimum dispatch-to-issue latency is 1 cycle: an entry dispatched with ready operands in cycle N issues in cycle N+1 if `mem_ready=1`.
- A cdb broadcast in cycle N makes the entry issuable in cycle N+1.
- `disp_ready` does not see a same-cycle pop: when full, dispatch is refused even if the head issues that cycle.
- Throughput: one issue per cycle while `mem_ready` stays high.
  - `mem_ctrl` drops `mem_ready` for AHB accesses.
  - The head is held stable until `mem_ready` returns.

## Test plan
- Reset, then dispatch `LW` with `rs1_ready=1`, rs1=0x100, imm=4, Pdst=3 in cycle 0 → cycle 1 shows `mem_issue_en=1`, rs1_value=0x100, imm=4, Pdst=3; `count` returns to 0 in cycle 2.
- Dispatch `SW` with rs2 tag 7 not ready, followed by a ready `LW` → nothing issues until `cdb1_valid` with tag 7 and value 0xDEAD. The SW issues the next cycle with rs2_value=0xDEAD, and the LW issues after it.
- Fill 8 entries with `mem_ready=0` → `disp_ready=0`, `count=8`, a 9th dispatch is ignored. Then raise `mem_ready` → 8 consecutive issues in order, with the pointers wrapping correctly.
- Dispatch with `rs1_ready=0` and tag 5 while `cdb0_valid`, tag 5, value 0x40 in the same cycle → the entry issues the next cycle with rs1_value=0x40.
- With 4 entries queued, assert `flush` together with `disp_valid` → the next cycle has `count=0`, `mem_issue_en=0`, and the flushed dispatch is not stored.
- Assert `rst` asynchronously mid-stream → outputs go to 0 and `disp_ready` goes to 1 without a clock edge.
